// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table extractor: FSM states, combination
// count and the mapping from input combination to truth-table bit.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    COMMIT = 2'd3
  } tt_state_t;

  localparam int TT_N_IN = 3;
  localparam int N_COMB  = 2 ** TT_N_IN;

  // Combination 0 lands in the MSB so the hex value reads like our gate names.
  function automatic int tt_bit_index(input int k, input int n_comb = N_COMB);
    return n_comb - 1 - k;
  endfunction

endpackage

// File: rtl/tt_sample_window.sv
// Settle/sample timing for one input combination plus the stability compare
// across the consecutive samples taken for that combination.
module tt_sample_window
  import tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int SAMPLES       = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  tt_state_t i_state,
  input  logic      i_dut_out,
  output logic      o_settle_done,
  output logic      o_sample_first,
  output logic      o_sample_last,
  output logic      o_sample_value,
  output logic      o_sample_unstable
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(SAMPLES + 1);

  logic [SW-1:0] r_settle_cnt;
  logic [MW-1:0] r_sample_cnt;
  logic          r_first_val;
  logic          r_unst;
  logic          w_first;
  logic          w_value;
  logic          w_unstable;

  assign w_first    = (r_sample_cnt == MW'(SAMPLES - 1));
  assign w_value    = w_first ? i_dut_out : r_first_val;
  assign w_unstable = !w_first && (r_unst || (i_dut_out != r_first_val));

  // Counters reload whenever their state is not active, so each visit starts fresh.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_settle_cnt <= SW'(SETTLE_CYCLES - 1);
      r_sample_cnt <= MW'(SAMPLES - 1);
      r_first_val  <= 1'b0;
      r_unst       <= 1'b0;
    end else begin
      if (i_state == SETTLE) begin
        if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - 1'b1;
      end else begin
        r_settle_cnt <= SW'(SETTLE_CYCLES - 1);
      end
      if (i_state == SAMPLE) begin
        if (r_sample_cnt != '0) r_sample_cnt <= r_sample_cnt - 1'b1;
        r_first_val <= w_value;
        r_unst      <= w_unstable;
      end else begin
        r_sample_cnt <= MW'(SAMPLES - 1);
      end
    end
  end

  assign o_settle_done     = (r_settle_cnt == '0);
  assign o_sample_first    = w_first;
  assign o_sample_last     = (r_sample_cnt == '0);
  assign o_sample_value    = w_value;
  assign o_sample_unstable = w_unstable;

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps all input combinations into a gate, samples its output and commits
// the gate's hex truth-table identifier plus per-combination instability flags.
module truth_table_extractor
  import tt_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int SAMPLES       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      stim_out,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic [2**N_IN-1:0]   truth_table,
  output logic [2**N_IN-1:0]   unstable,
  output tt_state_t            dbg_state
);

  localparam int NC = 2 ** N_IN;

  tt_state_t         r_state;
  logic [N_IN-1:0]   r_stim;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic [NC-1:0]     r_tt;
  logic [NC-1:0]     r_un;
  logic [NC-1:0]     r_tt_sh;
  logic [NC-1:0]     r_un_sh;

  logic              w_settle_done;
  logic              w_sample_first;
  logic              w_sample_last;
  logic              w_sample_value;
  logic              w_sample_unstable;
  int                w_idx;
  logic [NC-1:0]     w_tt_next;
  logic [NC-1:0]     w_un_next;

  tt_sample_window #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .SAMPLES      (SAMPLES)
  ) u_window (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_state          (r_state),
    .i_dut_out        (dut_out),
    .o_settle_done    (w_settle_done),
    .o_sample_first   (w_sample_first),
    .o_sample_last    (w_sample_last),
    .o_sample_value   (w_sample_value),
    .o_sample_unstable(w_sample_unstable)
  );

  assign w_idx = tt_bit_index(int'(r_stim), NC);

  // The value bit is fixed by the first sample; the unstable bit by the last.
  always_comb begin
    w_tt_next = r_tt_sh;
    w_un_next = r_un_sh;
    for (int i = 0; i < NC; i++) begin
      if (i == w_idx) begin
        if (w_sample_first) w_tt_next[i] = w_sample_value;
        if (w_sample_last)  w_un_next[i] = w_sample_unstable;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_stim  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_tt    <= '0;
      r_un    <= '0;
      r_tt_sh <= '0;
      r_un_sh <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_stim  <= '0;
            r_tt_sh <= '0;
            r_un_sh <= '0;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (w_settle_done) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_tt_sh <= w_tt_next;
          r_un_sh <= w_un_next;
          if (w_sample_last) begin
            if (&r_stim) begin
              // Commit uses the merged value so the final sample is not lost.
              r_tt    <= w_tt_next;
              r_un    <= w_un_next;
              r_valid <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_stim  <= '0;
              r_state <= COMMIT;
            end else begin
              r_stim  <= r_stim + 1'b1;
              r_state <= SETTLE;
            end
          end
        end
        COMMIT: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stim_out    = r_stim;
  assign busy        = r_busy;
  assign done        = r_done;
  assign valid       = r_valid;
  assign truth_table = r_tt;
  assign unstable    = r_un;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Directed bench for truth_table_extractor: gate models on dut_out, latency,
// instability flagging, start filtering, mid-sweep reset and back-to-back runs.
module tb_truth_table_extractor;
  import tt_pkg::*;

  localparam int M_NAND = 0;
  localparam int M_BUF  = 1;
  localparam int M_ONE  = 2;
  localparam int M_ZERO = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       dut0;
  logic       dut1;
  int         mode0 = M_NAND;
  int         c3 = 0;

  logic [2:0] stim0, stim1;
  logic       busy0, done0, valid0, busy1, done1, valid1;
  logic [7:0] tt0, un0, tt1, un1;
  tt_state_t  st0, st1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  truth_table_extractor u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_out(dut0),
    .stim_out(stim0), .busy(busy0), .done(done0), .valid(valid0),
    .truth_table(tt0), .unstable(un0), .dbg_state(st0)
  );

  truth_table_extractor #(.N_IN(3), .SETTLE_CYCLES(2), .SAMPLES(2)) u_dut_m2 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(dut1),
    .stim_out(stim1), .busy(busy1), .done(done1), .valid(valid1),
    .truth_table(tt1), .unstable(un1), .dbg_state(st1)
  );

  // Gate models driven from the registered stimulus.
  always_comb begin
    dut0 = 1'b0;
    case (mode0)
      M_NAND: dut0 = ~&stim0;
      M_BUF:  dut0 = stim0[2];
      M_ONE:  dut0 = 1'b1;
      default: dut0 = 1'b0;
    endcase
  end

  // Second DUT sees 1 for combination 3 except in its last cycle.
  always @(posedge clk) begin
    if (stim1 != 3'd3) c3 <= 0;
    else c3 <= c3 + 1;
  end
  assign dut1 = (stim1 == 3'd3) && (c3 < 3);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_done0(output int lat);
    lat = 0;
    while (!done0 && lat < 200) begin
      tick();
      lat++;
    end
    if (!done0) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset stim_out", 32'(stim0), 32'h0);
    chk("reset busy", 32'(busy0), 32'h0);
    chk("reset done", 32'(done0), 32'h0);
    chk("reset valid", 32'(valid0), 32'h0);
    chk("reset truth_table", 32'(tt0), 32'h0);
    chk("reset unstable", 32'(un0), 32'h0);
    chk("reset state", 32'(st0), 32'(IDLE));
    chk("reset m2 truth_table", 32'(tt1), 32'h0);
  endtask

  task automatic test_sweep(input string name, input int mode, input logic [7:0] exp_tt);
    int lat;
    logic [7:0] prev_tt;
    mode0 = mode;
    prev_tt = tt0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk({name, " busy after accept"}, 32'(busy0), 32'h1);
    chk({name, " valid after accept"}, 32'(valid0), 32'h0);
    chk({name, " tt holds mid sweep"}, 32'(tt0), 32'(prev_tt));
    wait_done0(lat);
    chk({name, " latency"}, 32'(lat), 32'd24);
    chk({name, " truth_table"}, 32'(tt0), 32'(exp_tt));
    chk({name, " unstable"}, 32'(un0), 32'h0);
    chk({name, " valid"}, 32'(valid0), 32'h1);
    chk({name, " busy at done"}, 32'(busy0), 32'h0);
    tick();
    chk({name, " done one cycle"}, 32'(done0), 32'h0);
    chk({name, " state idle"}, 32'(st0), 32'(IDLE));
  endtask

  task automatic test_unstable();
    int lat;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 200) begin
      tick();
      lat++;
    end
    chk("m2 latency", 32'(lat), 32'd32);
    chk("m2 truth_table", 32'(tt1), 32'h10);
    chk("m2 unstable", 32'(un1), 32'h10);
    chk("m2 valid", 32'(valid1), 32'h1);
    tick();
  endtask

  task automatic test_start_ignored();
    int n_done;
    mode0 = M_NAND;
    n_done = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c < 24) chk($sformatf("stim seq c%0d", c), 32'(stim0), 32'(c / 3));
      if (c == 24) chk("ignored done at 24", 32'(done0), 32'h1);
      if (done0) n_done++;
      start0 = (c == 5 || c == 10);
      tick();
    end
    start0 = 1'b0;
    chk("ignored done count", 32'(n_done), 32'd1);
    chk("ignored truth_table", 32'(tt0), 32'hFE);
    chk("ignored state idle", 32'(st0), 32'(IDLE));
  endtask

  task automatic test_reset_mid();
    mode0 = M_NAND;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 0; c < 11; c++) tick();
    chk("mid busy before reset", 32'(busy0), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid reset stim_out", 32'(stim0), 32'h0);
    chk("mid reset busy", 32'(busy0), 32'h0);
    chk("mid reset valid", 32'(valid0), 32'h0);
    chk("mid reset truth_table", 32'(tt0), 32'h0);
    chk("mid reset unstable", 32'(un0), 32'h0);
    chk("mid reset state", 32'(st0), 32'(IDLE));
    test_sweep("after reset nand3", M_NAND, 8'hFE);
  endtask

  task automatic test_back_to_back();
    int lat;
    mode0 = M_NAND;
    start0 = 1'b1;
    tick();
    wait_done0(lat);
    chk("b2b first latency", 32'(lat), 32'd24);
    chk("b2b first tt", 32'(tt0), 32'hFE);
    tick();
    chk("b2b commit exit idle", 32'(st0), 32'(IDLE));
    chk("b2b valid in idle", 32'(valid0), 32'h1);
    tick();
    chk("b2b reaccept busy", 32'(busy0), 32'h1);
    chk("b2b reaccept valid drop", 32'(valid0), 32'h0);
    for (int c = 0; c < 10; c++) tick();
    chk("b2b tt between commits", 32'(tt0), 32'hFE);
    lat = 0;
    while (!done0 && lat < 200) begin
      tick();
      lat++;
    end
    chk("b2b second latency", 32'(lat + 10), 32'd24);
    chk("b2b second tt", 32'(tt0), 32'hFE);
    chk("b2b second valid", 32'(valid0), 32'h1);
    start0 = 1'b0;
    tick();
    tick();
    chk("b2b stops idle", 32'(st0), 32'(IDLE));
  endtask

  initial begin
    test_reset();
    test_sweep("nand3", M_NAND, 8'hFE);
    test_sweep("buf in1", M_BUF, 8'h0F);
    test_sweep("const1", M_ONE, 8'hFF);
    test_sweep("const0", M_ZERO, 8'h00);
    test_unstable();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
